// File: rtl/data_memory_io_pkg.sv
// Shared constants and types for the data-side memory map and its I/O timer.
package data_memory_io_pkg;

    localparam int unsigned ADDR_GPIO_OUT = 32'h400;
    localparam int unsigned ADDR_GPIO_IN  = 32'h401;
    localparam int unsigned ADDR_TCTRL    = 32'h402;
    localparam int unsigned ADDR_TPRESC   = 32'h403;
    localparam int unsigned ADDR_TCMP     = 32'h404;
    localparam int unsigned ADDR_TCOUNT   = 32'h405;

    localparam int EN_BIT         = 0;
    localparam int AUTORELOAD_BIT = 1;
    localparam int FLAG_BIT       = 2;

    // Field order matches the bit indices above (en is bit 0).
    typedef struct packed {
        logic flag;
        logic autoreload;
        logic en;
    } tctrl_t;

endpackage

// File: rtl/data_memory_io_timer.sv
// Programmable timer: prescaler, 16-bit counter, compare flag and interrupt.
module io_timer
    import data_memory_io_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             ctrl_we,
    input  logic             presc_we,
    input  logic             cmp_we,
    input  logic             count_we,
    input  logic [WIDTH-1:0] wr_data,
    output tctrl_t           ctrl_out,
    output logic [WIDTH-1:0] presc_out,
    output logic [WIDTH-1:0] cmp_out,
    output logic [WIDTH-1:0] count_out,
    output logic             irq_out
);

    tctrl_t           ctrl_q, ctrl_d;
    logic [WIDTH-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic             tick;
    logic             match;
    logic             flag_set;
    logic             flag_clr;

    always_comb begin
        tick     = ctrl_q.en && (pcnt_q == presc_q);
        match    = (count_q == cmp_q);
        flag_set = tick && match && !count_we;
        flag_clr = ctrl_we && wr_data[FLAG_BIT];

        pcnt_d = pcnt_q;
        if (presc_we || ctrl_we) begin
            pcnt_d = '0;
        end else if (ctrl_q.en) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end

        // A software write to the counter overrides any tick that cycle.
        count_d = count_q;
        if (count_we) begin
            count_d = wr_data;
        end else if (tick) begin
            count_d = (match && ctrl_q.autoreload) ? '0 : count_q + 1'b1;
        end

        ctrl_d = ctrl_q;
        if (ctrl_we) begin
            ctrl_d.en         = wr_data[EN_BIT];
            ctrl_d.autoreload = wr_data[AUTORELOAD_BIT];
        end
        // Setting the flag takes priority over a write-1-clear.
        if (flag_set) begin
            ctrl_d.flag = 1'b1;
        end else if (flag_clr) begin
            ctrl_d.flag = 1'b0;
        end

        presc_d = presc_we ? wr_data : presc_q;
        cmp_d   = cmp_we ? wr_data : cmp_q;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            cmp_q   <= '0;
            count_q <= '0;
            pcnt_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            cmp_q   <= cmp_d;
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign ctrl_out  = ctrl_q;
    assign presc_out = presc_q;
    assign cmp_out   = cmp_q;
    assign count_out = count_q;
    assign irq_out   = ctrl_q.flag;

endmodule

// File: rtl/data_memory_io.sv
// Data-bus memory subsystem: word RAM, GPIO and timer behind a single-cycle read mux.
module data_memory_io
    import data_memory_io_pkg::*;
#(
    parameter int OPERAND_ADDRESS_WIDTH  = 11,
    parameter int INSTRUCTION_DATA_WIDTH = 16,
    parameter int RAM_DEPTH              = 1024,
    parameter int GPIO_WIDTH             = 16
) (
    input  logic                              clock_in,
    input  logic                              reset_in,
    input  logic [OPERAND_ADDRESS_WIDTH-1:0]  data_address_in,
    input  logic [INSTRUCTION_DATA_WIDTH-1:0] data_in,
    input  logic                              data_wr_in,
    output logic [INSTRUCTION_DATA_WIDTH-1:0] data_out,
    input  logic [GPIO_WIDTH-1:0]             gpio_in,
    output logic [GPIO_WIDTH-1:0]             gpio_out,
    output logic                              timer_irq_out
);

    localparam int AW     = OPERAND_ADDRESS_WIDTH;
    localparam int DW     = INSTRUCTION_DATA_WIDTH;
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    localparam logic [AW-1:0] A_GPIO_OUT = AW'(ADDR_GPIO_OUT);
    localparam logic [AW-1:0] A_GPIO_IN  = AW'(ADDR_GPIO_IN);
    localparam logic [AW-1:0] A_TCTRL    = AW'(ADDR_TCTRL);
    localparam logic [AW-1:0] A_TPRESC   = AW'(ADDR_TPRESC);
    localparam logic [AW-1:0] A_TCMP     = AW'(ADDR_TCMP);
    localparam logic [AW-1:0] A_TCOUNT   = AW'(ADDR_TCOUNT);

    logic [DW-1:0]         ram_mem [RAM_DEPTH];
    logic                  ram_sel;
    logic [RAM_AW-1:0]     ram_idx;

    logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_WIDTH-1:0] gpio_sync1_q, gpio_sync1_d;
    logic [GPIO_WIDTH-1:0] gpio_sync2_q, gpio_sync2_d;

    logic                  we_gpio_out, we_tctrl, we_tpresc, we_tcmp, we_tcount;
    tctrl_t                timer_ctrl;
    logic [DW-1:0]         timer_presc, timer_cmp, timer_count;
    logic [DW-1:0]         rdata;

    assign ram_sel = 32'(data_address_in) < RAM_DEPTH;
    assign ram_idx = data_address_in[RAM_AW-1:0];

    always_comb begin
        we_gpio_out = data_wr_in && (data_address_in == A_GPIO_OUT);
        we_tctrl    = data_wr_in && (data_address_in == A_TCTRL);
        we_tpresc   = data_wr_in && (data_address_in == A_TPRESC);
        we_tcmp     = data_wr_in && (data_address_in == A_TCMP);
        we_tcount   = data_wr_in && (data_address_in == A_TCOUNT);
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clock_in) begin
        if (data_wr_in && ram_sel) begin
            ram_mem[ram_idx] <= data_in;
        end
    end

    always_comb begin
        gpio_sync1_d = gpio_in;
        gpio_sync2_d = gpio_sync1_q;
        gpio_out_d   = we_gpio_out ? data_in[GPIO_WIDTH-1:0] : gpio_out_q;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            gpio_out_q   <= '0;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
        end else begin
            gpio_out_q   <= gpio_out_d;
            gpio_sync1_q <= gpio_sync1_d;
            gpio_sync2_q <= gpio_sync2_d;
        end
    end

    io_timer #(
        .WIDTH(DW)
    ) u_timer (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .ctrl_we  (we_tctrl),
        .presc_we (we_tpresc),
        .cmp_we   (we_tcmp),
        .count_we (we_tcount),
        .wr_data  (data_in),
        .ctrl_out (timer_ctrl),
        .presc_out(timer_presc),
        .cmp_out  (timer_cmp),
        .count_out(timer_count),
        .irq_out  (timer_irq_out)
    );

    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            rdata = ram_mem[ram_idx];
        end else begin
            case (data_address_in)
                A_GPIO_OUT: rdata[GPIO_WIDTH-1:0]     = gpio_out_q;
                A_GPIO_IN:  rdata[GPIO_WIDTH-1:0]     = gpio_sync2_q;
                A_TCTRL:    rdata[$bits(tctrl_t)-1:0] = timer_ctrl;
                A_TPRESC:   rdata                     = timer_presc;
                A_TCMP:     rdata                     = timer_cmp;
                A_TCOUNT:   rdata                     = timer_count;
                default:    rdata                     = '0;
            endcase
        end
    end

    assign data_out = rdata;
    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_data_memory_io.sv
// Directed self-checking bench for data_memory_io: RAM, GPIO, timer and async reset.
module tb_data_memory_io;

    logic        clock_in;
    logic        reset_in;
    logic [10:0] data_address_in;
    logic [15:0] data_in;
    logic        data_wr_in;
    logic [15:0] data_out;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        timer_irq_out;

    int n_checks;
    int n_fail;

    data_memory_io dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .data_address_in(data_address_in),
        .data_in        (data_in),
        .data_wr_in     (data_wr_in),
        .data_out       (data_out),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out),
        .timer_irq_out  (timer_irq_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [10:0] addr, input logic [15:0] wdata);
        data_address_in = addr;
        data_in         = wdata;
        data_wr_in      = 1'b1;
        @(posedge clock_in);
        #1;
        data_wr_in      = 1'b0;
    endtask

    task automatic read_addr(input logic [10:0] addr);
        data_address_in = addr;
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset_in        = 1'b1;
        data_address_in = 11'h402;
        data_in         = '0;
        data_wr_in      = 1'b0;
        gpio_in         = '0;

        #2;
        check_output("reset_tctrl", data_out, 16'h0000);
        check_output("reset_gpio_out", gpio_out, 16'h0000);
        check_output("reset_irq", {15'b0, timer_irq_out}, 16'h0000);
        read_addr(11'h405);
        check_output("reset_tcount", data_out, 16'h0000);
        @(posedge clock_in);
        #1;
        reset_in = 1'b0;

        $display("[TB] RAM and unmapped reads");
        apply_stimulus(11'h010, 16'hBEEF);
        apply_stimulus(11'h3FF, 16'h1234);
        read_addr(11'h010);
        check_output("ram_010", data_out, 16'hBEEF);
        read_addr(11'h3FF);
        check_output("ram_3ff", data_out, 16'h1234);
        read_addr(11'h7FF);
        check_output("unmapped_7ff", data_out, 16'h0000);

        $display("[TB] GPIO");
        apply_stimulus(11'h400, 16'h00A5);
        check_output("gpio_out_a5", gpio_out, 16'h00A5);
        read_addr(11'h400);
        check_output("gpio_out_readback", data_out, 16'h00A5);
        read_addr(11'h401);
        gpio_in = 16'h5A5A;
        #1;
        check_output("gpio_in_sync0", data_out, 16'h0000);
        step(1);
        check_output("gpio_in_sync1", data_out, 16'h0000);
        step(1);
        check_output("gpio_in_sync2", data_out, 16'h5A5A);

        $display("[TB] Timer autoreload");
        apply_stimulus(11'h403, 16'h0003);
        apply_stimulus(11'h404, 16'h0004);
        apply_stimulus(11'h402, 16'h0003);
        read_addr(11'h405);
        step(4);
        check_output("tcount_tick1", data_out, 16'h0001);
        step(15);
        check_output("tcount_before_match", data_out, 16'h0004);
        check_output("irq_before_match", {15'b0, timer_irq_out}, 16'h0000);
        step(1);
        check_output("tcount_reloaded", data_out, 16'h0000);
        check_output("irq_on_match", {15'b0, timer_irq_out}, 16'h0001);
        read_addr(11'h402);
        check_output("tctrl_flag_set", data_out, 16'h0007);
        apply_stimulus(11'h402, 16'h0007);
        read_addr(11'h402);
        check_output("tctrl_flag_cleared", data_out, 16'h0003);

        $display("[TB] Timer wrap without autoreload");
        apply_stimulus(11'h402, 16'h0000);
        apply_stimulus(11'h403, 16'h0000);
        apply_stimulus(11'h404, 16'h0002);
        apply_stimulus(11'h405, 16'hFFFE);
        apply_stimulus(11'h402, 16'h0001);
        read_addr(11'h405);
        check_output("tcount_preset", data_out, 16'hFFFE);
        step(1);
        check_output("tcount_ffff", data_out, 16'hFFFF);
        step(1);
        check_output("tcount_0000", data_out, 16'h0000);
        step(1);
        check_output("tcount_0001", data_out, 16'h0001);
        step(1);
        check_output("tcount_0002", data_out, 16'h0002);
        check_output("irq_before_0002_tick", {15'b0, timer_irq_out}, 16'h0000);
        step(1);
        check_output("tcount_0003", data_out, 16'h0003);
        check_output("irq_after_0002_tick", {15'b0, timer_irq_out}, 16'h0001);

        $display("[TB] Simultaneous events");
        apply_stimulus(11'h405, 16'h0100);
        read_addr(11'h405);
        check_output("tcount_sw_wins", data_out, 16'h0100);
        step(1);
        check_output("tcount_after_sw", data_out, 16'h0101);
        apply_stimulus(11'h402, 16'h0005);
        read_addr(11'h402);
        check_output("flag_clear_no_match", data_out, 16'h0001);
        apply_stimulus(11'h405, 16'h0002);
        apply_stimulus(11'h402, 16'h0005);
        read_addr(11'h402);
        check_output("flag_set_beats_clear", data_out, 16'h0005);
        check_output("irq_set_beats_clear", {15'b0, timer_irq_out}, 16'h0001);

        $display("[TB] Asynchronous reset mid-count");
        apply_stimulus(11'h400, 16'hFFFF);
        check_output("gpio_out_ffff", gpio_out, 16'hFFFF);
        read_addr(11'h405);
        #2;
        reset_in = 1'b1;
        #1;
        check_output("async_gpio_out", gpio_out, 16'h0000);
        check_output("async_tcount", data_out, 16'h0000);
        check_output("async_irq", {15'b0, timer_irq_out}, 16'h0000);
        read_addr(11'h402);
        check_output("async_tctrl", data_out, 16'h0000);
        @(posedge clock_in);
        #1;
        reset_in = 1'b0;
        read_addr(11'h010);
        check_output("ram_kept_over_reset", data_out, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
